// File: rtl/metronome_pkg.sv
// Shared definitions for the metronome control path: clock rate, gesture
// FSM state encoding and a milliseconds-to-cycles helper.
package metronome_pkg;

    localparam int unsigned CLK_HZ = 12_000_000;

    localparam logic [2:0] GS_IDLE   = 3'd0;
    localparam logic [2:0] GS_PRESS1 = 3'd1;
    localparam logic [2:0] GS_WAIT2  = 3'd2;
    localparam logic [2:0] GS_PRESS2 = 3'd3;
    localparam logic [2:0] GS_LONG   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = GS_IDLE,
        ST_PRESS1 = GS_PRESS1,
        ST_WAIT2  = GS_WAIT2,
        ST_PRESS2 = GS_PRESS2,
        ST_LONG   = GS_LONG
    } gesture_state_t;

    // 64-bit intermediate so long durations at CLK_HZ do not overflow.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        longint unsigned cycles;
        cycles = (longint'(CLK_HZ) * longint'(ms)) / 64'd1000;
        return cycles[31:0];
    endfunction

endpackage

// File: rtl/gesture_timer.sv
// Cycle timer for the gesture FSM: clear / count-enable with a terminal-count
// flag against a per-state limit selected by the caller.
module gesture_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // In normal operation the count only ever meets limit-1 exactly; the >=
    // makes a timeout that was held off for a cycle fire on the next one
    // instead of letting the counter run on to wrap.
    assign done = enable && (count_reg >= (limit - CNT_W'(1)));

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced press/release pulses of one button into short, double
// and long presses plus auto-repeat ticks while a long press is held.
module button_gesture_decoder
    import metronome_pkg::*;
#(
    parameter int unsigned LONG_PRESS_CYCLES = ms_to_cycles(600),
    parameter int unsigned DOUBLE_GAP_CYCLES = ms_to_cycles(300),
    parameter int unsigned REPEAT_CYCLES     = ms_to_cycles(100),
    parameter int          CNT_W             = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pressed,
    input  logic btn_released,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_tick,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LIMIT   = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LIMIT    = CNT_W'(DOUBLE_GAP_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_LIMIT = CNT_W'(REPEAT_CYCLES);

    gesture_state_t state_reg, state_next;

    logic short_reg,  short_next;
    logic double_reg, double_next;
    logic long_reg,   long_next;
    logic repeat_reg, repeat_next;
    logic held_reg;

    logic             pressed_evt;
    logic             released_evt;
    logic             violation;
    logic             timer_clear;
    logic             timer_enable;
    logic             timer_done;
    logic             repeat_wrap;
    logic [CNT_W-1:0] timer_limit;

    // Both pulses at once is a protocol violation: neither counts as an event
    // and no timeout may change state in that cycle.
    assign violation    = btn_pressed & btn_released;
    assign pressed_evt  = btn_pressed & ~btn_released;
    assign released_evt = btn_released & ~btn_pressed;

    assign timer_enable = (state_reg == ST_PRESS1) || (state_reg == ST_WAIT2) ||
                          (state_reg == ST_LONG);

    always_comb begin
        timer_limit = REPEAT_LIMIT;
        case (state_reg)
            ST_PRESS1: timer_limit = LONG_LIMIT;
            ST_WAIT2:  timer_limit = GAP_LIMIT;
            default:   timer_limit = REPEAT_LIMIT;
        endcase
    end

    gesture_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .limit  (timer_limit),
        .done   (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            short_reg  <= 1'b0;
            double_reg <= 1'b0;
            long_reg   <= 1'b0;
            repeat_reg <= 1'b0;
            held_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            short_reg  <= short_next;
            double_reg <= double_next;
            long_reg   <= long_next;
            repeat_reg <= repeat_next;
            held_reg   <= (state_next == ST_PRESS1) || (state_next == ST_PRESS2) ||
                          (state_next == ST_LONG);
        end
    end

    // Events are tested before timeouts in every state so an event landing on
    // the terminal count suppresses the timeout pulse.
    always_comb begin
        state_next  = state_reg;
        short_next  = 1'b0;
        double_next = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;
        repeat_wrap = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (pressed_evt) begin
                    state_next = ST_PRESS1;
                end
            end
            ST_PRESS1: begin
                if (released_evt) begin
                    state_next = ST_WAIT2;
                end else if (timer_done && !violation) begin
                    state_next = ST_LONG;
                    long_next  = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (pressed_evt) begin
                    state_next = ST_PRESS2;
                end else if (timer_done && !violation) begin
                    state_next = ST_IDLE;
                    short_next = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (released_evt) begin
                    state_next  = ST_IDLE;
                    double_next = 1'b1;
                end
            end
            ST_LONG: begin
                if (released_evt) begin
                    state_next = ST_IDLE;
                end else if (timer_done && !violation) begin
                    repeat_next = 1'b1;
                    repeat_wrap = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        timer_clear = (state_next != state_reg) || repeat_wrap;
    end

    assign short_press  = short_reg;
    assign double_press = double_reg;
    assign long_press   = long_reg;
    assign repeat_tick  = repeat_reg;
    assign held         = held_reg;

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Directed bench for button_gesture_decoder with short timing parameters
// (LONG=20, GAP=10, REPEAT=4); every cycle's outputs are checked.
module tb_button_gesture_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_pressed = 1'b0;
    logic btn_released = 1'b0;
    logic short_press, double_press, long_press, repeat_tick, held;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected output vector bits: {held, short, double, long, repeat}
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] H    = 5'b10000;
    localparam logic [4:0] S    = 5'b01000;
    localparam logic [4:0] D    = 5'b00100;
    localparam logic [4:0] L    = 5'b00010;
    localparam logic [4:0] R    = 5'b00001;

    logic [4:0] outs;
    assign outs = {held, short_press, double_press, long_press, repeat_tick};

    button_gesture_decoder #(
        .LONG_PRESS_CYCLES (20),
        .DOUBLE_GAP_CYCLES (10),
        .REPEAT_CYCLES     (4),
        .CNT_W             (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_pressed  (btn_pressed),
        .btn_released (btn_released),
        .short_press  (short_press),
        .double_press (double_press),
        .long_press   (long_press),
        .repeat_tick  (repeat_tick),
        .held         (held)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, actual[4:0], expected[4:0]);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, check outputs #1 later.
    task automatic cyc(input logic p, input logic r, input logic [4:0] exp, input string tag);
        btn_pressed  = p;
        btn_released = r;
        @(posedge clk);
        #1;
        btn_pressed  = 1'b0;
        btn_released = 1'b0;
        check_value(tag, {27'd0, outs}, {27'd0, exp});
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_value(tag, {27'd0, outs}, {27'd0, NONE});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 check_value("reset", {27'd0, outs}, {27'd0, NONE});
        @(negedge clk);
        rst = 1'b0;

        // 1: short press, release at +5, short_press at +15
        cyc(1'b1, 1'b0, H, "s1.e0");
        for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b0, H, $sformatf("s1.e%0d", k));
        cyc(1'b0, 1'b1, NONE, "s1.e5");
        for (int k = 6; k <= 14; k++) cyc(1'b0, 1'b0, NONE, $sformatf("s1.e%0d", k));
        cyc(1'b0, 1'b0, S, "s1.e15");
        cyc(1'b0, 1'b0, NONE, "s1.e16");
        $display("[TB] scenario 1 short press done");

        // 2: double press
        cyc(1'b1, 1'b0, H, "s2.e0");
        for (int k = 1; k <= 4; k++) cyc(1'b0, 1'b0, H, $sformatf("s2.e%0d", k));
        cyc(1'b0, 1'b1, NONE, "s2.e5");
        cyc(1'b0, 1'b0, NONE, "s2.e6");
        cyc(1'b0, 1'b0, NONE, "s2.e7");
        cyc(1'b1, 1'b0, H, "s2.e8");
        for (int k = 9; k <= 14; k++) cyc(1'b0, 1'b0, H, $sformatf("s2.e%0d", k));
        cyc(1'b0, 1'b1, D, "s2.e15");
        for (int k = 16; k <= 30; k++) cyc(1'b0, 1'b0, NONE, $sformatf("s2.e%0d", k));
        $display("[TB] scenario 2 double press done");

        // 3: long press with repeat ticks at +24, +28, ..., +40
        cyc(1'b1, 1'b0, H, "s3.e0");
        for (int k = 1; k <= 40; k++) begin
            logic [4:0] e;
            e = H;
            if (k == 20) e = H | L;
            if (k > 20 && ((k - 20) % 4) == 0) e = H | R;
            cyc(1'b0, 1'b0, e, $sformatf("s3.e%0d", k));
        end
        cyc(1'b0, 1'b1, NONE, "s3.e41");
        for (int k = 42; k <= 50; k++) cyc(1'b0, 1'b0, NONE, $sformatf("s3.e%0d", k));
        $display("[TB] scenario 3 long press done");

        // 4: release at PRESS1 timer=19, press at WAIT2 timer=9
        cyc(1'b1, 1'b0, H, "s4.e0");
        for (int k = 1; k <= 19; k++) cyc(1'b0, 1'b0, H, $sformatf("s4.e%0d", k));
        cyc(1'b0, 1'b1, NONE, "s4.e20");
        for (int k = 21; k <= 29; k++) cyc(1'b0, 1'b0, NONE, $sformatf("s4.e%0d", k));
        cyc(1'b1, 1'b0, H, "s4.e30");
        for (int k = 31; k <= 35; k++) cyc(1'b0, 1'b0, H, $sformatf("s4.e%0d", k));
        cyc(1'b0, 1'b1, D, "s4.e36");
        cyc(1'b0, 1'b0, NONE, "s4.e37");
        $display("[TB] scenario 4 timeout boundaries done");

        // 5a: reset in LONG, later release gives nothing, next press starts fresh
        cyc(1'b1, 1'b0, H, "s5a.e0");
        for (int k = 1; k <= 19; k++) cyc(1'b0, 1'b0, H, $sformatf("s5a.e%0d", k));
        cyc(1'b0, 1'b0, H | L, "s5a.e20");
        cyc(1'b0, 1'b0, H, "s5a.e21");
        async_reset("s5a.rst");
        cyc(1'b0, 1'b1, NONE, "s5a.rel");
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, NONE, $sformatf("s5a.idle%0d", k));
        cyc(1'b1, 1'b0, H, "s5a.p0");
        cyc(1'b0, 1'b1, NONE, "s5a.p1");
        for (int k = 2; k <= 10; k++) cyc(1'b0, 1'b0, NONE, $sformatf("s5a.p%0d", k));
        cyc(1'b0, 1'b0, S, "s5a.p11");

        // 5b: reset in WAIT2 discards the pending short press
        cyc(1'b1, 1'b0, H, "s5b.e0");
        cyc(1'b0, 1'b0, H, "s5b.e1");
        cyc(1'b0, 1'b1, NONE, "s5b.e2");
        cyc(1'b0, 1'b0, NONE, "s5b.e3");
        async_reset("s5b.rst");
        for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0, NONE, $sformatf("s5b.idle%0d", k));
        cyc(1'b0, 1'b1, NONE, "s5b.rel");
        $display("[TB] scenario 5 async reset done");

        // 6a: simultaneous pulses in IDLE are ignored
        cyc(1'b1, 1'b1, NONE, "s6a.both");
        for (int k = 0; k < 12; k++) cyc(1'b0, 1'b0, NONE, $sformatf("s6a.idle%0d", k));

        // 6b: simultaneous pulses in PRESS1 ignored, timer keeps counting
        cyc(1'b1, 1'b0, H, "s6b.e0");
        for (int k = 1; k <= 19; k++)
            cyc((k == 5), (k == 5), H, $sformatf("s6b.e%0d", k));
        cyc(1'b0, 1'b0, H | L, "s6b.e20");
        cyc(1'b0, 1'b1, NONE, "s6b.e21");
        for (int k = 22; k <= 26; k++) cyc(1'b0, 1'b0, NONE, $sformatf("s6b.e%0d", k));
        $display("[TB] scenario 6 protocol violation done");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
